// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with 2-deep request budget, response FIFO and redirect discard
// Requests are gated so in-flight + discarded + buffered never exceeds the 2-entry FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_IF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_IF,
  output logic [31:0] instr_IF,
  output logic [31:0] pc_IF
);

  logic [31:0] r_pc;
  logic        r_run;
  logic [1:0]  r_out_cnt;
  logic [1:0]  r_disc_cnt;
  logic [1:0]  r_fifo_cnt;
  logic [31:0] r_inf_pc   [2];
  logic [31:0] r_fifo_pc  [2];
  logic [31:0] r_fifo_instr [2];

  logic [2:0]  w_used;
  logic [1:0]  w_pending;
  logic [1:0]  w_inf_idx;
  logic [1:0]  w_fifo_idx;
  logic        w_grant;
  logic        w_take;
  logic        w_drop;
  logic        w_pop;
  logic        w_unused;

  assign w_used     = {1'b0, r_out_cnt} + {1'b0, r_disc_cnt} + {1'b0, r_fifo_cnt};
  assign w_pending  = r_out_cnt + r_disc_cnt;
  assign imem_req   = r_run && !redirect_valid && (w_used < 3'd2);
  assign imem_addr  = {r_pc[31:2], 2'b00};
  assign w_grant    = imem_req && imem_gnt;
  assign w_drop     = imem_rvalid && (r_disc_cnt != 2'd0);
  assign w_take     = imem_rvalid && (r_disc_cnt == 2'd0) && (r_out_cnt != 2'd0);
  assign valid_IF   = (r_fifo_cnt != 2'd0);
  assign w_pop      = valid_IF && !stall_IF;
  assign w_inf_idx  = r_out_cnt - {1'b0, w_take};
  assign w_fifo_idx = r_fifo_cnt - {1'b0, w_pop};
  assign instr_IF   = valid_IF ? r_fifo_instr[0] : 32'h0;
  assign pc_IF      = valid_IF ? r_fifo_pc[0] : 32'h0;
  assign w_unused   = &{1'b0, redirect_pc[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc            <= RESET_PC;
      r_run           <= 1'b0;
      r_out_cnt       <= 2'd0;
      r_disc_cnt      <= 2'd0;
      r_fifo_cnt      <= 2'd0;
      r_inf_pc[0]     <= 32'h0;
      r_inf_pc[1]     <= 32'h0;
      r_fifo_pc[0]    <= 32'h0;
      r_fifo_pc[1]    <= 32'h0;
      r_fifo_instr[0] <= 32'h0;
      r_fifo_instr[1] <= 32'h0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        // every response still owed becomes a discard, minus one arriving right now
        r_pc       <= {redirect_pc[31:2], 2'b00};
        r_out_cnt  <= 2'd0;
        r_fifo_cnt <= 2'd0;
        r_disc_cnt <= (imem_rvalid && (w_pending != 2'd0)) ? w_pending - 2'd1 : w_pending;
      end else begin
        if (w_grant) r_pc <= r_pc + 32'd4;
        r_out_cnt  <= r_out_cnt - {1'b0, w_take} + {1'b0, w_grant};
        r_fifo_cnt <= r_fifo_cnt - {1'b0, w_pop} + {1'b0, w_take};
        if (w_drop) r_disc_cnt <= r_disc_cnt - 2'd1;

        if (w_take) r_inf_pc[0] <= r_inf_pc[1];
        if (w_grant) begin
          if (w_inf_idx == 2'd0) r_inf_pc[0] <= imem_addr;
          else                   r_inf_pc[1] <= imem_addr;
        end

        if (w_pop) begin
          r_fifo_pc[0]    <= r_fifo_pc[1];
          r_fifo_instr[0] <= r_fifo_instr[1];
        end
        if (w_take) begin
          if (w_fifo_idx == 2'd0) begin
            r_fifo_pc[0]    <= r_inf_pc[0];
            r_fifo_instr[0] <= imem_rdata;
          end else begin
            r_fifo_pc[1]    <= r_inf_pc[0];
            r_fifo_instr[1] <= imem_rdata;
          end
        end
      end
    end
  end

  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid |-> (r_out_cnt != 2'd0 || r_disc_cnt != 2'd0))
    else $warning("fetch_unit: stray imem_rvalid ignored");

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - queue-based reference model of fetch_unit with directed and random stimulus
// Memory model answers grants in order after a random latency; stale answers survive a reset.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_IF = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid_IF;
  logic [31:0] instr_IF;
  logic [31:0] pc_IF;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .stall_IF(stall_IF),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_IF(valid_IF), .instr_IF(instr_IF), .pc_IF(pc_IF)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  int          last_due;
  int          stale_left;
  logic [31:0] m_pc;
  logic [31:0] m_inflight[$];
  int          m_disc;
  logic [31:0] m_fpc[$];
  logic [31:0] m_finstr[$];
  bit          m_run;
  bit          p_rd, p_rv, p_st, p_grant;
  logic [31:0] p_rp, p_rdata;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  logic [31:0] deliv_pc[$];
  logic [31:0] deliv_instr[$];

  function automatic logic [31:0] f_instr(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void model_reset();
    m_pc = RESET_PC;
    m_inflight.delete();
    m_fpc.delete();
    m_finstr.delete();
    m_disc = 0;
    m_run = 0;
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle just ended.
  function automatic void model_step();
    int pending;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (p_rd) begin
      pending = m_inflight.size() + m_disc;
      m_disc = (p_rv && pending > 0) ? pending - 1 : pending;
      m_inflight.delete();
      m_fpc.delete();
      m_finstr.delete();
      m_pc = {p_rp[31:2], 2'b00};
    end else begin
      if (m_fpc.size() > 0 && !p_st) begin
        void'(m_fpc.pop_front());
        void'(m_finstr.pop_front());
      end
      if (p_rv) begin
        if (m_disc > 0) m_disc--;
        else if (m_inflight.size() > 0) begin
          m_fpc.push_back(m_inflight.pop_front());
          m_finstr.push_back(p_rdata);
        end
      end
      if (p_grant) begin
        m_inflight.push_back({m_pc[31:2], 2'b00});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1;
  endfunction

  function automatic bit model_req(input bit rd);
    return m_run && !rd && (m_inflight.size() + m_disc + m_fpc.size() < 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit g, input bit st, input bit rd,
                       input logic [31:0] rp, input int lat);
    bit          rv;
    bit          req;
    bit          ev;
    int          due;
    logic [31:0] rdata;
    @(posedge clk);
    #1;
    model_step();
    cyc++;
    rv = 0;
    rdata = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1;
      rdata = f_instr(mem_q[0].addr);
      void'(mem_q.pop_front());
      if (stale_left > 0) stale_left--;
    end
    if (rst) begin
      reset_n = 1'b0;
      model_reset();
      stale_left = mem_q.size();
    end else begin
      reset_n = 1'b1;
    end
    imem_rvalid    = rv;
    imem_rdata     = rdata;
    stall_IF       = st;
    redirect_valid = rd;
    redirect_pc    = rp;
    imem_gnt       = g && (stale_left == 0);
    req = model_req(rd);
    if (req && imem_gnt) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: {m_pc[31:2], 2'b00}, due: due});
    end
    p_rd = rd; p_rv = rv; p_st = st; p_rp = rp; p_rdata = rdata;
    p_grant = req && imem_gnt;
    #1;
    ev = (m_fpc.size() > 0);
    check("imem_req", {31'h0, imem_req}, {31'h0, req});
    check("imem_addr", imem_addr, {m_pc[31:2], 2'b00});
    check("valid_IF", {31'h0, valid_IF}, {31'h0, ev});
    check("pc_IF", pc_IF, ev ? m_fpc[0] : 32'h0);
    check("instr_IF", instr_IF, ev ? m_finstr[0] : 32'h0);
    if (reset_n && valid_IF && !st && !rd) begin
      deliv_pc.push_back(pc_IF);
      deliv_instr.push_back(instr_IF);
    end
  endtask

  initial begin
    int mark;
    n_cmp = 0; n_bad = 0; cyc = 0; last_due = 0; stale_left = 0;
    p_rd = 0; p_rv = 0; p_st = 0; p_grant = 0; p_rp = 0; p_rdata = 0;
    model_reset();

    repeat (3) cycle(1, 0, 0, 0, 32'h0, 1);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, valid_IF}, 32'h0);
    check("rst_pc", pc_IF, 32'h0);
    check("rst_instr", instr_IF, 32'h0);

    cycle(0, 1, 0, 0, 32'h0, 1);
    cycle(0, 1, 0, 0, 32'h0, 1);
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, RESET_PC);

    repeat (12) cycle(0, 1, 0, 0, 32'h0, 1);
    if (deliv_pc.size() < 4) check("stream_count", deliv_pc.size(), 32'd4);
    else begin
      for (int i = 0; i < 4; i++) begin
        check("stream_pc", deliv_pc[i], RESET_PC + 32'(4 * i));
        check("stream_instr", deliv_instr[i], f_instr(RESET_PC + 32'(4 * i)));
      end
    end

    repeat (5) cycle(0, 1, 1, 0, 32'h0, 1);
    repeat (6) cycle(0, 1, 0, 0, 32'h0, 1);
    repeat (3) cycle(0, 0, 0, 0, 32'h0, 1);
    cycle(0, 1, 0, 0, 32'h0, 1);

    repeat (6) cycle(0, 0, 0, 0, 32'h0, 1);
    mark = deliv_pc.size();
    cycle(0, 1, 0, 0, 32'h0, 3);
    cycle(0, 1, 0, 0, 32'h0, 3);
    cycle(0, 1, 0, 1, 32'h0000_0103, 1);
    repeat (12) cycle(0, 1, 0, 0, 32'h0, 1);
    if (deliv_pc.size() <= mark) check("redir_count", deliv_pc.size(), mark + 1);
    else check("redir_first_pc", deliv_pc[mark], 32'h0000_0100);

    repeat (6) cycle(0, 0, 0, 0, 32'h0, 1);
    mark = deliv_pc.size();
    cycle(0, 1, 0, 0, 32'h0, 3);
    cycle(0, 1, 0, 0, 32'h0, 3);
    cycle(1, 1, 0, 0, 32'h0, 1);
    repeat (14) cycle(0, 1, 0, 0, 32'h0, 1);
    if (deliv_pc.size() <= mark) check("rst_deliv_count", deliv_pc.size(), mark + 1);
    else check("rst_first_pc", deliv_pc[mark], RESET_PC);

    repeat (2500) begin
      if ($urandom_range(0, 99) == 0) begin
        cycle(1, 1, 0, 0, 32'h0, 1);
        repeat ($urandom_range(0, 1)) cycle(1, 1, 0, 0, 32'h0, 1);
      end
      cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0, $urandom, $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
